rca_share_arbiter: RTL and testbench

//  Time-shares a single ripple_carry_adder_56bit between NREQ requesters.
//  - Round-robin arbitration; operands registered before the adder.
//  - Carry chain is given SETTLE_CYC clock cycles (multicycle path) before the sum is captured.
//  - One result per transaction is returned on a valid/ready response channel, tagged with the requester index.

---
 rtl/rca_share_pkg.sv | 36 +++
 rtl/ripple_carry_adder_56bit.sv | 27 ++
 rtl/rca_share_arbiter.sv | 134 +++++++++++++
 tb/tb_rca_share_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_share_pkg.sv
// Shared types and helpers for the time-shared ripple-carry adder arbiter.
package rca_share_pkg;

  localparam int DEF_WIDTH      = 56;
  localparam int DEF_NREQ       = 4;
  localparam int DEF_IDW        = 2;
  localparam int DEF_SETTLE_CYC = 2;
  localparam int MAX_NREQ       = 16;
  localparam int PICK_W         = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  // First valid index at or after ptr, wrapping modulo nreq; 0 when none valid.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                                input logic [PICK_W-1:0]   ptr,
                                                input int                  nreq);
    logic              found;
    logic [PICK_W-1:0] pick;
    logic [PICK_W-1:0] idx;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      idx = PICK_W'((int'(ptr) + i) % nreq);
      if ((i < nreq) && !found && valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_56bit.sv
// Plain bit-serial-carry adder; the carry chain is deliberately slow and is
// given several clock cycles to settle by the surrounding arbiter.
module ripple_carry_adder_56bit #(
  parameter int WIDTH = 56
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic w_ci;
    logic w_co;
    if (g == 0) begin : g_first
      assign w_ci = i_cin;
    end else begin : g_rest
      assign w_ci = g_bit[g-1].w_co;
    end
    assign o_sum[g] = i_a[g] ^ i_b[g] ^ w_ci;
    assign w_co     = (i_a[g] & i_b[g]) | (w_ci & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = g_bit[WIDTH-1].w_co;

endmodule

// File: rtl/rca_share_arbiter.sv
// Round-robin front end that time-shares one ripple-carry adder between NREQ
// requesters, allowing SETTLE_CYC cycles for the carry chain before capture.
module rca_share_arbiter
  import rca_share_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NREQ       = DEF_NREQ,
  parameter int IDW        = DEF_IDW,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic [NREQ-1:0]      o_req_ready,
  output logic                 o_rsp_valid,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [WIDTH:0]       o_rsp_result,
  input  logic                 i_rsp_ready,
  output logic                 o_busy
);

  localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  // Handshakes: a request transfers when i_req_valid[k] && o_req_ready[k] at a
  // rising edge; ready is a combinational one-hot grant raised only in IDLE.
  // A response transfers when o_rsp_valid && i_rsp_ready; while valid is high
  // and ready is low, id and result hold and no new request is granted.

  state_e            r_state;
  state_e            w_next_state;
  logic [CNTW-1:0]   r_cnt;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    r_id;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH:0]    r_result;

  logic [PICK_W-1:0] w_pick;
  logic              w_any;
  logic              w_accept;
  logic [IDW-1:0]    w_win_id;
  logic [WIDTH-1:0]  w_win_a;
  logic [WIDTH-1:0]  w_win_b;
  logic [WIDTH-1:0]  w_sum;
  logic              w_cout;

  // Operands reach the adder only from registers that stay frozen through SETTLE.
  ripple_carry_adder_56bit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_pick = rr_pick(MAX_NREQ'(i_req_valid), PICK_W'(r_rr_ptr), NREQ);
  assign w_any  = |i_req_valid;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_win_id     = '0;
    w_win_a      = '0;
    w_win_b      = '0;
    o_req_ready  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_pick == PICK_W'(k)) begin
        w_win_id = IDW'(k);
        w_win_a  = i_req_a[k*WIDTH +: WIDTH];
        w_win_b  = i_req_b[k*WIDTH +: WIDTH];
      end
    end
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_accept              = 1'b1;
          o_req_ready[w_win_id] = 1'b1;
          w_next_state          = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a   <= w_win_a;
        r_b   <= w_win_b;
        r_id  <= w_win_id;
        r_cnt <= CNTW'(SETTLE_CYC - 1);
      end
      if (r_state == SETTLE) begin
        if (r_cnt == '0) begin
          r_result <= {w_cout, w_sum};
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if ((r_state == RESP) && i_rsp_ready) begin
        r_rr_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
      end
    end
  end

  assign o_rsp_valid  = (r_state == RESP);
  assign o_rsp_id     = r_id;
  assign o_rsp_result = r_result;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_rca_share_arbiter.sv
// Directed-vector bench for rca_share_arbiter (NREQ=4, SETTLE_CYC=2).
module tb_rca_share_arbiter;

  localparam int WIDTH = 56;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  // ---------------- clock / reset ----------------
  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       o_req_ready;
  logic                  o_rsp_valid;
  logic [IDW-1:0]        o_rsp_id;
  logic [WIDTH:0]        o_rsp_result;
  logic                  rsp_ready;
  logic                  o_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [IDW+WIDTH:0] exp_q[$];
  logic [WIDTH:0]     exp_tab[NREQ];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rca_share_arbiter #(
    .WIDTH      (WIDTH),
    .NREQ       (NREQ),
    .IDW        (IDW),
    .SETTLE_CYC (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_req_ready  (o_req_ready),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result),
    .i_rsp_ready  (rsp_ready),
    .o_busy       (o_busy)
  );

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[k*WIDTH +: WIDTH] = a;
    req_b[k*WIDTH +: WIDTH] = b;
  endtask

  task automatic scramble_op(input int k);
    set_op(k, WIDTH'({$urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 0)}),
              WIDTH'({$urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 0)}));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  o_req_ready,  0);
    check({tag, "_rspv"},   o_rsp_valid,  0);
    check({tag, "_id"},     o_rsp_id,     0);
    check({tag, "_result"}, o_rsp_result, 0);
    check({tag, "_busy"},   o_busy,       0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check_idle_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Raise one request, expect its immediate grant, then drop it and corrupt operands.
  task automatic issue(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output int t);
    @(posedge clk); #1;
    set_op(k, a, b);
    req_valid[k] = 1'b1;
    @(negedge clk);
    check("grant", o_req_ready, 64'(1 << k));
    t = cyc;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    scramble_op(k);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_rsp_valid) break;
    end
    check("rsp_timeout", o_rsp_valid, 1);
  endtask

  task automatic finish_rsp(input int k, input logic [WIDTH:0] exp, input int t);
    wait_rsp();
    check("latency",    cyc - t,      3);
    check("rsp_id",     o_rsp_id,     k);
    check("rsp_result", o_rsp_result, exp);
    check("rsp_ready0", o_req_ready,  0);
    @(negedge clk);
    check("post_busy", o_busy,      0);
    check("post_rspv", o_rsp_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int grants;
    int last_g;
    int seen;
    logic [IDW+WIDTH:0] e;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    exp_tab[0] = 57'h15;
    exp_tab[1] = 57'h1_00_0000_0000_0000;
    exp_tab[2] = 57'h13_3557_799B_BDDF;
    exp_tab[3] = 57'h1_00_0000_0000_0000;

    @(negedge clk);
    check_idle_outputs("init");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Simple add on req1.
    issue(1, 56'h1, 56'h2, t);
    finish_rsp(1, 57'h3, t);

    // Full carry-out case on req0.
    issue(0, 56'hFF_FFFF_FFFF_FFFF, 56'hFF_FFFF_FFFF_FFFF, t);
    finish_rsp(0, 57'h1_FFFF_FFFF_FFFF_FE, t);

    // All four continuously valid from rr_ptr=0: 0,1,2,3,0 four cycles apart.
    do_reset();
    set_op(0, 56'h10, 56'h05);
    set_op(1, 56'h80_0000_0000_0000, 56'h80_0000_0000_0000);
    set_op(2, 56'h12_3456_789A_BCDE, 56'h01_0101_0101_0101);
    set_op(3, 56'hFF_FFFF_FFFF_FFFF, 56'h1);
    @(posedge clk); #1;
    req_valid = 4'hF;
    grants = 0;
    last_g = 0;
    for (int c = 0; c < 60 && !(grants == 5 && exp_q.size() == 0); c++) begin
      @(negedge clk);
      if (o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rr_unexp_rsp", o_rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("rr_rsp", {o_rsp_id, o_rsp_result}, e);
        end
      end
      if (o_req_ready != '0) begin
        check("rr_grant", o_req_ready, 64'(1 << (grants % 4)));
        if (grants > 0) check("rr_spacing", cyc - last_g, 4);
        last_g = cyc;
        exp_q.push_back({IDW'(grants % 4), exp_tab[grants % 4]});
        grants++;
      end
      @(posedge clk); #1;
      if (grants >= 5) req_valid = '0;
    end
    check("rr_count", grants, 5);
    check("rr_drain", exp_q.size(), 0);

    // Backpressure in RESP with req3 waiting; rr_ptr is 1 here so req2 goes first.
    rsp_ready = 1'b0;
    issue(2, 56'h00_0000_FFFF_FFFF, 56'h1, t);
    wait_rsp();
    check("bp_latency", cyc - t, 3);
    @(posedge clk); #1;
    set_op(3, 56'h55_5555_5555_5555, 56'hAA_AAAA_AAAA_AAAA);
    req_valid[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rspv",   o_rsp_valid,  1);
      check("bp_id",     o_rsp_id,     2);
      check("bp_result", o_rsp_result, 57'h1_0000_0000);
      check("bp_ready",  o_req_ready,  0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_last_rspv", o_rsp_valid, 1);
    @(negedge clk);
    check("bp_idle_busy", o_busy,      0);
    check("bp_next_gnt",  o_req_ready, 4'b1000);
    t = cyc;
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    scramble_op(3);
    finish_rsp(3, 57'hFF_FFFF_FFFF_FFFF, t);

    // After id=3, req0 and req2 valid: wrap to req0, then req2.
    @(posedge clk); #1;
    set_op(0, 56'h5, 56'h6);
    set_op(2, 56'h7, 56'h8);
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    @(negedge clk);
    check("wrap_gnt0", o_req_ready, 4'b0001);
    t = cyc;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    finish_rsp(0, 57'hB, t);
    check("wrap_gnt2", o_req_ready, 4'b0100);
    t = cyc;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    finish_rsp(2, 57'hF, t);

    // Reset during SETTLE (rr_ptr is 3 beforehand).
    issue(1, 56'h3, 56'h4, t);
    check("mid_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   o_busy,      0);
    check("arst_rspv",   o_rsp_valid, 0);
    check("arst_ready",  o_req_ready, 0);
    check("arst_result", o_rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_rsp_valid) seen++;
    end
    check("arst_no_rsp", seen, 0);
    @(posedge clk); #1;
    set_op(1, 56'h3, 56'h4);
    set_op(3, 56'h9, 56'h9);
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    @(negedge clk);
    check("arst_gnt_low", o_req_ready, 4'b0010);
    t = cyc;
    @(posedge clk); #1;
    req_valid = '0;
    finish_rsp(1, 57'h7, t);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
